// File: rtl/dut_vector_sequencer.sv
// Vector sequencer: drives a combinational netlist from a valid/ready stream or a counter sweep, captures each response.
// Latency: response captured SETTLE cycles after dut_in updates; SETTLE+2 (stream) / SETTLE+1 (sweep) cycles per vector.
// Backpressure: result held stable until res_ready; vec_ready high only in FETCH. Define SEQ_MISR_EN for the sig signature output.
module dut_vector_sequencer #(
    parameter int               IN_W      = 20,
    parameter int               OUT_W     = 40,
    parameter int               SETTLE    = 1,
    parameter logic [OUT_W-1:0] MISR_POLY = 40'h40_0028_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IN_W-1:0]  sweep_last,
    input  logic             vec_valid,
    input  logic [IN_W-1:0]  vec_data,
    input  logic             vec_last,
    output logic             vec_ready,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             res_valid,
    output logic [OUT_W-1:0] res_data,
    output logic [IN_W-1:0]  res_vec,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
`ifdef SEQ_MISR_EN
    ,
    output logic [OUT_W-1:0] sig
`endif
);

    if (SETTLE < 1 || SETTLE > 15 || MISR_POLY == '0) begin : g_bad_param
        $error("SETTLE must be 1..15 and MISR_POLY nonzero");
    end

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETTLE, S_HOLD, S_DONE} state_t;

    state_t          state, state_nxt;
    logic            mode_q;
    logic            last_q;
    logic [IN_W-1:0] sweep_last_q;
    logic [3:0]      cnt;
    logic            is_last;
    logic            accept_start, load_vec, capture, res_hs, inc_vec;

    // Sweep ends on the inclusive bound, so the counter can never wrap.
    assign is_last = mode_q ? (dut_in == sweep_last_q) : last_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        load_vec     = 1'b0;
        capture      = 1'b0;
        res_hs       = 1'b0;
        inc_vec      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = mode ? S_SETTLE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (vec_valid) begin
                    load_vec  = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_hs = 1'b1;
                    if (is_last) begin
                        state_nxt = S_DONE;
                    end else if (!mode_q) begin
                        state_nxt = S_FETCH;
                    end else begin
                        inc_vec   = 1'b1;
                        state_nxt = S_SETTLE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mode_q       <= 1'b0;
            last_q       <= 1'b0;
            sweep_last_q <= '0;
            cnt          <= 4'd0;
            dut_in       <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_vec      <= '0;
        end else begin
            vec_ready <= (state_nxt == S_FETCH);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            if (accept_start) begin
                mode_q       <= mode;
                sweep_last_q <= sweep_last;
                if (mode) begin
                    dut_in <= '0;
                    cnt    <= CNT_INIT;
                end
            end
            if (load_vec) begin
                dut_in <= vec_data;
                last_q <= vec_last;
                cnt    <= CNT_INIT;
            end
            if (state == S_SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (capture) begin
                res_data  <= dut_out;
                res_vec   <= dut_in;
                res_valid <= 1'b1;
            end
            if (res_hs) res_valid <= 1'b0;
            if (inc_vec) begin
                dut_in <= dut_in + IN_W'(1);
                cnt    <= CNT_INIT;
            end
        end
    end

`ifdef SEQ_MISR_EN
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            sig <= '0;
        end else if (capture) begin
            sig <= {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : '0) ^ dut_out;
        end
    end
`endif

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Bench for dut_vector_sequencer: two instances (SETTLE=1 and SETTLE=3) on a loopback netlist stub,
// randomized runs scored against a queue-based model of the expected result stream and timing.
module tb_dut_vector_sequencer;
    localparam int               IN_W  = 20;
    localparam int               OUT_W = 40;
    localparam logic [OUT_W-1:0] POLY  = 40'h40_0028_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, mode, vec_valid, vec_last, res_ready, sel;
    logic [IN_W-1:0] sweep_last, vec_data;

    logic             start_a, start_b;
    logic             vr_a, vr_b, rv_a, rv_b, busy_a, busy_b, done_a, done_b;
    logic [IN_W-1:0]  din_a, din_b, rvec_a, rvec_b;
    logic [OUT_W-1:0] dout_a, dout_b, rdat_a, rdat_b;
    logic             vr_o, rv_o, busy_o, done_o;
    logic [IN_W-1:0]  din_o, rvec_o;
    logic [OUT_W-1:0] rdat_o;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign dout_a  = {din_a, ~din_a};
    assign dout_b  = {din_b, ~din_b};
    assign vr_o    = sel ? vr_b   : vr_a;
    assign rv_o    = sel ? rv_b   : rv_a;
    assign busy_o  = sel ? busy_b : busy_a;
    assign done_o  = sel ? done_b : done_a;
    assign din_o   = sel ? din_b  : din_a;
    assign rvec_o  = sel ? rvec_b : rvec_a;
    assign rdat_o  = sel ? rdat_b : rdat_a;
`ifdef SEQ_MISR_EN
    logic [OUT_W-1:0] sig_a, sig_b, sig_o;
    assign sig_o = sel ? sig_b : sig_a;
`endif

    dut_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_seq1 (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .sweep_last(sweep_last),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_last(vec_last), .vec_ready(vr_a),
        .dut_in(din_a), .dut_out(dout_a), .res_valid(rv_a), .res_data(rdat_a), .res_vec(rvec_a),
        .res_ready(res_ready), .busy(busy_a), .done(done_a)
`ifdef SEQ_MISR_EN
        , .sig(sig_a)
`endif
    );

    dut_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) u_seq3 (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .sweep_last(sweep_last),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_last(vec_last), .vec_ready(vr_b),
        .dut_in(din_b), .dut_out(dout_b), .res_valid(rv_b), .res_data(rdat_b), .res_vec(rvec_b),
        .res_ready(res_ready), .busy(busy_b), .done(done_b)
`ifdef SEQ_MISR_EN
        , .sig(sig_b)
`endif
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s, input logic [OUT_W-1:0] d);
        return (s << 1) ^ (s[OUT_W-1] ? POLY : '0) ^ d;
    endfunction

    // Expected result vectors, in order; the stream stimulus is the same list.
    logic [IN_W-1:0] exp_q[$];

    task automatic run(input bit m, input logic [IN_W-1:0] slast, input int stall_at,
                       input int stall_len, input bit rnd_rdy, input bit poke);
        int               settle, s_edge, trig, fetch_ref, prev_cap, stall_left, ndone;
        logic [IN_W-1:0]  stim[$];
        logic [IN_W-1:0]  final_vec;
        logic [OUT_W-1:0] misr, held_dat;
        bit               rv_prev, rhs, vhs, end_pending, fin, poked, poke_now;
        settle = sel ? 3 : 1;
        stim = exp_q;
        final_vec = exp_q[exp_q.size()-1];
        misr = '0; held_dat = '0;
        prev_cap = -1; stall_left = 0; ndone = 0;
        rv_prev = 0; end_pending = 0; fin = 0; poked = 0;
        mode = m; sweep_last = slast; vec_valid = 0; res_ready = 0; start = 1;
        @(negedge clk);
        start = 0;
        s_edge = edge_n; trig = s_edge; fetch_ref = s_edge;
        check_eq("start_busy", busy_o, 1);
        if (m) check_eq("sweep_first_vec", din_o, 0);
        else   check_eq("fetch_ready", vr_o, 1);
        for (int c = 0; c < 3000 && !fin; c++) begin
            poke_now = poke && !poked && busy_o && (edge_n == trig) && !rv_o && (m || trig != s_edge);
            if (poke_now) poked = 1;
            start = poke_now;
            mode  = poke_now ? ~m : m;
            if (!m && stim.size() > 0) begin
                vec_valid = 1; vec_data = stim[0]; vec_last = (stim.size() == 1);
            end else begin
                vec_valid = m ? 1'($urandom_range(0, 1)) : 1'b0;
                vec_data = IN_W'($urandom); vec_last = 1'($urandom_range(0, 1));
            end
            res_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_left > 0) begin res_ready = 0; stall_left--; end
            vhs = !m && vec_valid && vr_o;
            rhs = rv_o && res_ready;
            if (vhs) begin
                check_eq("fetch_gap", edge_n + 1 - fetch_ref, 1);
                trig = edge_n + 1;
                void'(stim.pop_front());
            end
            if (rhs) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_result", rv_o, 0);
                end else begin
                    check_eq("res_vec", rvec_o, exp_q[0]);
                    check_eq("res_data", rdat_o, {exp_q[0], ~exp_q[0]});
                    void'(exp_q.pop_front());
                    fetch_ref = edge_n + 1;
                    if (m) trig = edge_n + 1;
                    end_pending = (exp_q.size() == 0);
                end
            end
            held_dat = rdat_o;
            @(negedge clk);
            if (done_o) ndone++;
            if (end_pending) begin
                check_eq("done_pulse", done_o, 1);
                check_eq("done_busy", busy_o, 1);
                check_eq("final_dut_in", din_o, final_vec);
                check_eq("done_res_valid", rv_o, 0);
`ifdef SEQ_MISR_EN
                check_eq("sig_final", sig_o, misr);
`endif
                fin = 1;
            end else if (rv_o && !rv_prev) begin
                check_eq("capture_latency", edge_n - trig, settle);
                if (m && !rnd_rdy && prev_cap >= 0) check_eq("sweep_period", edge_n - prev_cap, settle + 1);
                prev_cap = edge_n;
                if (exp_q.size() > 0) misr = misr_step(misr, {exp_q[0], ~exp_q[0]});
`ifdef SEQ_MISR_EN
                check_eq("sig_capture", sig_o, misr);
`endif
                if (exp_q.size() == stim.size() + 0 && stall_at >= 0 && !m && 0) stall_left = 0;
                if (stall_at >= 0 && (final_vec == final_vec) && prev_cap >= 0 && stall_at == 0) stall_left = stall_len;
            end else if (rv_prev && !rhs) begin
                check_eq("hold_valid", rv_o, 1);
                check_eq("hold_data", rdat_o, held_dat);
                check_eq("hold_no_fetch", vr_o, 0);
            end
            if (rv_o && !rv_prev && stall_at > 0) stall_at--;
            else if (rv_o && !rv_prev && stall_at == 0) stall_at = -1;
            rv_prev = rv_o;
        end
        check_eq("run_finished", fin, 1);
        start = 0; vec_valid = 0; res_ready = 0; mode = 0;
        @(negedge clk);
        check_eq("done_cleared", done_o, 0);
        check_eq("idle_busy", busy_o, 0);
        check_eq("done_count", ndone, 1);
`ifdef SEQ_MISR_EN
        check_eq("sig_held", sig_o, misr);
`endif
        exp_q.delete();
    endtask

    initial begin : main
        int              w, n;
        bit              m;
        logic [IN_W-1:0] last;
        rst = 1; start = 0; mode = 0; sweep_last = '0; vec_valid = 0; vec_data = '0;
        vec_last = 0; res_ready = 0; sel = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_res_valid", rv_a, 0);
        check_eq("rst_vec_ready", vr_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_dut_in", din_a, 0);
        check_eq("rst_res_data", rdat_a, 0);
        check_eq("rst_res_vec", rvec_a, 0);
        check_eq("rst_busy3", busy_b, 0);
        rst = 0;
        @(negedge clk);

        // Reset while a result is held.
        start = 1; @(negedge clk); start = 0;
        vec_valid = 1; vec_data = 20'h00005; vec_last = 0; res_ready = 0;
        w = 0;
        while (!rv_o && w < 20) begin @(negedge clk); w++; end
        check_eq("hold_reached", rv_o, 1);
        check_eq("hold_res_vec", rvec_o, 20'h00005);
        vec_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        check_eq("midrst_res_valid", rv_o, 0);
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_dut_in", din_o, 0);
        check_eq("midrst_vec_ready", vr_o, 0);
        @(negedge clk);

        exp_q = '{20'hABCDE};
        run(0, '0, -1, 0, 0, 0);
        exp_q = '{20'd1, 20'd2, 20'd3};
        run(0, '0, 1, 5, 0, 0);
        sel = 1;
        exp_q = '{20'd0, 20'd1, 20'd2, 20'd3};
        run(1, 20'd3, -1, 0, 0, 0);
        exp_q = '{20'd0, 20'd1};
        run(1, 20'd1, -1, 0, 0, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(IN_W'($urandom));
        run(0, '0, -1, 0, 0, 1);

        for (int r = 0; r < 8; r++) begin
            sel = r[0];
            m = 1'($urandom_range(0, 1));
            last = '0;
            if (m) begin
                last = IN_W'($urandom_range(0, 6));
                for (int v = 0; v <= int'(last); v++) exp_q.push_back(IN_W'(v));
            end else begin
                n = $urandom_range(1, 6);
                for (int v = 0; v < n; v++) exp_q.push_back(IN_W'($urandom));
            end
            run(m, last, $urandom_range(0, 1), $urandom_range(1, 4), 1, r[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
